// File: rtl/rattlesnake_fetch_mem_port_pkg.sv
// Shared widths, FSM state encoding and compressed-instruction detect for the fetch memory port.
package rattlesnake_fetch_mem_port_pkg;

    localparam int XLEN           = 32;
    localparam int PC_BITWIDTH    = 32;
    localparam int MEM_ADDR_BITS  = 16;
    localparam int WORD_ADDR_BITS = MEM_ADDR_BITS - 1;
    localparam int HALF           = XLEN / 2;

    // A halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
    localparam logic [1:0] UNCOMPRESSED_LSBS = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        WT0  = 3'd2,
        RD1  = 3'd3,
        WT1  = 3'd4,
        DONE = 3'd5
    } fetch_state_t;

    function automatic logic is_compressed(input logic [1:0] lsbs);
        return lsbs != UNCOMPRESSED_LSBS;
    endfunction

endpackage

// File: rtl/rattlesnake_fetch_word_buffer.sv
// One-entry word buffer (address, data, valid) used by the fetch port to skip repeated SRAM reads.
module rattlesnake_fetch_word_buffer
    import rattlesnake_fetch_mem_port_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      invalidate,
    input  logic                      fill_en,
    input  logic [WORD_ADDR_BITS-1:0] fill_addr,
    input  logic [XLEN-1:0]           fill_data,
    input  logic [WORD_ADDR_BITS-1:0] lookup_addr,
    output logic                      hit,
    output logic [XLEN-1:0]           data
);

    logic                      valid_q;
    logic [WORD_ADDR_BITS-1:0] addr_q;
    logic [XLEN-1:0]           data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr;
            data_q  <= fill_data;
        end
    end

    assign hit  = valid_q && (addr_q == lookup_addr);
    assign data = data_q;

endmodule

// File: rtl/rattlesnake_fetch_mem_port.sv
// Instruction-fetch port: assembles aligned/misaligned (16/32-bit) instructions from a word SRAM.
// Optional word buffer enabled by RATTLESNAKE_FETCH_WORD_BUFFER_EN.
module rattlesnake_fetch_mem_port
    import rattlesnake_fetch_mem_port_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sync_reset,
    input  logic                      read_mem_enable,
    input  logic [PC_BITWIDTH-1:0]    read_mem_addr,
    output logic                      mem_read_done,
    output logic [XLEN-1:0]           mem_data,
    output logic [MEM_ADDR_BITS-1:0]  mem_addr_ack,
    output logic                      sram_req,
    input  logic                      sram_gnt,
    output logic [WORD_ADDR_BITS-1:0] sram_addr,
    input  logic [XLEN-1:0]           sram_rdata,
    output logic                      busy,
    output fetch_state_t              state_dbg
);

    // SRAM handshake: sram_req/sram_addr stay stable until the cycle sram_gnt is high;
    // sram_rdata is consumed exactly one cycle after that req&gnt cycle.

    fetch_state_t              state_q, state_d;
    logic [MEM_ADDR_BITS-1:0]  haddr_q, haddr_d;
    logic [XLEN-1:0]           data_q, data_d;
    logic [WORD_ADDR_BITS-1:0] word0, word1, word_cur;
    logic                      in_rd, in_wt, capture, rd_hit;
    logic [XLEN-1:0]           rdata_sel;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{read_mem_addr[PC_BITWIDTH-1:MEM_ADDR_BITS+1], read_mem_addr[0]};

    // haddr_q is the halfword address; its bit 0 marks a misaligned fetch.
    assign word0    = haddr_q[MEM_ADDR_BITS-1:1];
    assign word1    = word0 + WORD_ADDR_BITS'(1);
    assign word_cur = (state_q == RD1 || state_q == WT1) ? word1 : word0;
    assign in_rd    = (state_q == RD0) || (state_q == RD1);
    assign in_wt    = (state_q == WT0) || (state_q == WT1);
    assign capture  = in_wt && !sync_reset && !read_mem_enable;

`ifdef RATTLESNAKE_FETCH_WORD_BUFFER_EN
    logic            hit_q;
    logic            buf_hit;
    logic [XLEN-1:0] buf_data;

    rattlesnake_fetch_word_buffer u_word_buffer (
        .clk         (clk),
        .reset_n     (reset_n),
        .invalidate  (sync_reset),
        .fill_en     (capture),
        .fill_addr   (word_cur),
        .fill_data   (rdata_sel),
        .lookup_addr (word_cur),
        .hit         (buf_hit),
        .data        (buf_data)
    );

    assign rd_hit    = in_rd && buf_hit;
    assign rdata_sel = hit_q ? buf_data : sram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hit_q <= 1'b0;
        else          hit_q <= rd_hit;
    end
`else
    assign rd_hit    = 1'b0;
    assign rdata_sel = sram_rdata;
`endif

    always_comb begin
        state_d = state_q;
        haddr_d = haddr_q;
        data_d  = data_q;
        if (sync_reset) begin
            state_d = IDLE;
            data_d  = '0;
        end else if (read_mem_enable) begin
            // A new request abandons whatever is in flight, including a DONE cycle's successor.
            state_d = RD0;
            haddr_d = read_mem_addr[MEM_ADDR_BITS:1];
            data_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RD0:  if (rd_hit || sram_gnt) state_d = WT0;
                WT0: begin
                    if (!haddr_q[0]) begin
                        data_d  = rdata_sel;
                        state_d = DONE;
                    end else begin
                        data_d  = {{HALF{1'b0}}, rdata_sel[XLEN-1:HALF]};
                        state_d = is_compressed(rdata_sel[HALF+1:HALF]) ? DONE : RD1;
                    end
                end
                RD1:  if (rd_hit || sram_gnt) state_d = WT1;
                WT1: begin
                    data_d[XLEN-1:HALF] = rdata_sel[HALF-1:0];
                    state_d             = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            haddr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            haddr_q <= haddr_d;
            data_q  <= data_d;
        end
    end

    assign sram_req      = in_rd && !rd_hit && !sync_reset;
    assign sram_addr     = in_rd ? word_cur : '0;
    assign mem_read_done = (state_q == DONE) && !sync_reset;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign mem_data      = data_q;
    assign mem_addr_ack  = haddr_q;
    assign state_dbg     = state_q;

endmodule
